ring_sequence_checker: RTL and testbench

Receiving end of the one-hot ring counter link. It samples a 4-bit one-hot word on a strobe, checks that each sample is the rotate-left successor of the previous one (1→2→4→8→1), and locks after a run of correct transitions. It counts sequence errors and drives the board LEDs and 7-segment display with the decoded position and status. It sits beside the ring-counter generator in `top`; `ring_in` comes from the generator or from `SWI[7:4]`.

---
 rtl/ring_pkg.sv | 37 +++
 rtl/seg7_hex.sv | 32 +++
 rtl/ring_sequence_checker.sv | 119 +++++++++++
 tb/tb_ring_sequence_checker.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared types, 7-segment glyphs and one-hot helpers for the ring counter link.
package ring_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } ring_state_t;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_A    = 7'b1110111;
  localparam logic [6:0] SEG_B    = 7'b1111100;
  localparam logic [6:0] SEG_C    = 7'b0111001;
  localparam logic [6:0] SEG_D    = 7'b1011110;
  localparam logic [6:0] SEG_E    = 7'b1111001;
  localparam logic [6:0] SEG_F    = 7'b1110001;
  localparam logic [6:0] SEG_DASH = 7'b1000000;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [3:0] rotl4(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/seg7_hex.sv
// Combinational hex digit to 7-segment glyph decoder, shared with the generator display.
module seg7_hex
  import ring_pkg::*;
(
  input  logic [3:0] value_i,
  output logic [6:0] glyph_o
);

  always_comb begin
    glyph_o = SEG_DASH;
    case (value_i)
      4'h0: glyph_o = SEG_0;
      4'h1: glyph_o = SEG_1;
      4'h2: glyph_o = SEG_2;
      4'h3: glyph_o = SEG_3;
      4'h4: glyph_o = SEG_4;
      4'h5: glyph_o = SEG_5;
      4'h6: glyph_o = SEG_6;
      4'h7: glyph_o = SEG_7;
      4'h8: glyph_o = SEG_8;
      4'h9: glyph_o = SEG_9;
      4'hA: glyph_o = SEG_A;
      4'hB: glyph_o = SEG_B;
      4'hC: glyph_o = SEG_C;
      4'hD: glyph_o = SEG_D;
      4'hE: glyph_o = SEG_E;
      4'hF: glyph_o = SEG_F;
      default: glyph_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/ring_sequence_checker.sv
// Receive-side checker for the one-hot ring link: tracks rotate-left succession,
// locks after LOCK_COUNT good transitions and counts errors seen while locked.
//
// state  | meaning
// HUNT   | no legal base sample held
// SYNC   | base held, counting consecutive good transitions
// LOCKED | LOCK_COUNT good transitions seen; errors are counted here
module ring_sequence_checker
  import ring_pkg::*;
#(
  parameter int LOCK_COUNT = 3,
  parameter int NBITS_ERR  = 4
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic                 sample,
  input  logic [3:0]           ring_in,
  output logic                 locked,
  output logic [1:0]           index,
  output logic [NBITS_ERR-1:0] err_count,
  output logic                 mismatch,
  output logic                 illegal,
  output logic [7:0]           SEG
);

  localparam int GW = $clog2(LOCK_COUNT + 1);

  ring_state_t          state_q, state_d;
  logic [3:0]           prev_q, prev_d;
  logic                 have_prev_q, have_prev_d;
  logic [GW-1:0]        good_cnt_q, good_cnt_d;
  logic [GW-1:0]        good_inc;
  logic [NBITS_ERR-1:0] err_q, err_d;
  logic [1:0]           index_q, index_d;
  logic                 mismatch_q, mismatch_d;
  logic                 illegal_q, illegal_d;
  logic                 count_err;
  logic [6:0]           glyph;

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q     <= HUNT;
      prev_q      <= 4'd0;
      have_prev_q <= 1'b0;
      good_cnt_q  <= '0;
      err_q       <= '0;
      index_q     <= 2'd0;
      mismatch_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      good_cnt_q  <= good_cnt_d;
      err_q       <= err_d;
      index_q     <= index_d;
      mismatch_q  <= mismatch_d;
      illegal_q   <= illegal_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    good_cnt_d  = good_cnt_q;
    index_d     = index_q;
    mismatch_d  = 1'b0;
    illegal_d   = 1'b0;
    count_err   = 1'b0;
    good_inc    = good_cnt_q + 1'b1;

    if (sample) begin
      if (!is_onehot4(ring_in)) begin
        illegal_d   = 1'b1;
        count_err   = (state_q == LOCKED);
        state_d     = HUNT;
        prev_d      = 4'd0;
        have_prev_d = 1'b0;
        good_cnt_d  = '0;
        index_d     = 2'd0;
      end else begin
        prev_d  = ring_in;
        index_d = {ring_in[3] | ring_in[2], ring_in[3] | ring_in[1]};
        if (!have_prev_q) begin
          have_prev_d = 1'b1;
          state_d     = SYNC;
          good_cnt_d  = '0;
        end else if (ring_in == rotl4(prev_q)) begin
          // Once locked the run counter is frozen; only a break can clear it.
          if (state_q != LOCKED) begin
            good_cnt_d = good_inc;
            if (good_inc == GW'(LOCK_COUNT)) state_d = LOCKED;
          end
        end else begin
          mismatch_d = 1'b1;
          count_err  = (state_q == LOCKED);
          state_d    = SYNC;
          good_cnt_d = '0;
        end
      end
    end

    err_d = (count_err && (err_q != {NBITS_ERR{1'b1}})) ? err_q + 1'b1 : err_q;
  end

  seg7_hex u_seg7_hex (
    .value_i (prev_q),
    .glyph_o (glyph)
  );

  assign locked    = (state_q == LOCKED);
  assign index     = index_q;
  assign err_count = err_q;
  assign mismatch  = mismatch_q;
  assign illegal   = illegal_q;
  assign SEG       = {(err_q != '0), (state_q == LOCKED) ? glyph : SEG_DASH};

endmodule

// File: tb/tb_ring_sequence_checker.sv
// Directed plus randomized bench for ring_sequence_checker against an abstract sequence model.
module tb_ring_sequence_checker;

  localparam int LOCK = 3;
  localparam int NERR = 4;
  localparam int ERR_MAX = (1 << NERR) - 1;

  logic            clk_2 = 1'b0;
  logic            reset;
  logic            sample;
  logic [3:0]      ring_in;
  logic            locked;
  logic [1:0]      index;
  logic [NERR-1:0] err_count;
  logic            mismatch;
  logic            illegal;
  logic [7:0]      SEG;

  int total = 0;
  int bad   = 0;

  // Model: position value (0 = none held), run length, lock flag, error tally.
  int m_prev;
  int m_run;
  bit m_locked;
  int m_err;
  bit m_mm;
  bit m_il;

  logic [6:0] glyph_tab [4];

  ring_sequence_checker #(.LOCK_COUNT(LOCK), .NBITS_ERR(NERR)) dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .sample    (sample),
    .ring_in   (ring_in),
    .locked    (locked),
    .index     (index),
    .err_count (err_count),
    .mismatch  (mismatch),
    .illegal   (illegal),
    .SEG       (SEG)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int succ_of(input int p);
    return (p == 8) ? 1 : p * 2;
  endfunction

  function automatic logic [3:0] next_word();
    return (m_prev == 0) ? 4'd1 : 4'(succ_of(m_prev));
  endfunction

  task automatic model_reset();
    m_prev = 0; m_run = 0; m_locked = 0; m_err = 0; m_mm = 0; m_il = 0;
  endtask

  task automatic bump_err();
    if (m_locked && m_err < ERR_MAX) m_err++;
  endtask

  task automatic model_sample(input logic [3:0] w);
    int v;
    v = int'(w);
    m_mm = 0;
    m_il = 0;
    if ($countones(w) != 1) begin
      m_il = 1;
      bump_err();
      m_locked = 0; m_prev = 0; m_run = 0;
    end else if (m_prev == 0) begin
      m_prev = v; m_run = 0; m_locked = 0;
    end else if (v == succ_of(m_prev)) begin
      m_prev = v;
      if (!m_locked) begin
        m_run++;
        if (m_run >= LOCK) m_locked = 1;
      end
    end else begin
      m_mm = 1;
      bump_err();
      m_locked = 0; m_prev = v; m_run = 0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] exp_seg;
    int exp_idx;
    exp_idx = (m_prev == 0) ? 0 : $clog2(m_prev);
    exp_seg[6:0] = m_locked ? glyph_tab[exp_idx] : 7'b1000000;
    exp_seg[7]   = (m_err != 0);
    chk({tag, ".locked"},   32'(locked),    32'(m_locked));
    chk({tag, ".index"},    32'(index),     32'(exp_idx));
    chk({tag, ".err"},      32'(err_count), 32'(m_err));
    chk({tag, ".mismatch"}, 32'(mismatch),  32'(m_mm));
    chk({tag, ".illegal"},  32'(illegal),   32'(m_il));
    chk({tag, ".seg"},      32'(SEG),       32'(exp_seg));
  endtask

  task automatic step(input string tag, input bit s, input logic [3:0] w, input bit r);
    @(negedge clk_2);
    reset   = r;
    sample  = s;
    ring_in = w;
    @(posedge clk_2);
    if (r) model_reset();
    else if (s) model_sample(w);
    else begin
      m_mm = 0;
      m_il = 0;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    glyph_tab[0] = 7'b0000110;
    glyph_tab[1] = 7'b1011011;
    glyph_tab[2] = 7'b1100110;
    glyph_tab[3] = 7'b1111111;
    reset = 1'b1; sample = 1'b0; ring_in = 4'd0;
    model_reset();

    step("rst", 1'b1, 4'd1, 1'b1);
    step("rst2", 1'b0, 4'd0, 1'b1);
    chk("rst.seg_const", 32'(SEG), 32'h40);

    // Lock on 1,2,4,8
    step("lock1", 1'b1, 4'd1, 1'b0);
    step("lock2", 1'b1, 4'd2, 1'b0);
    step("lock4", 1'b1, 4'd4, 1'b0);
    chk("lock.not_yet", 32'(locked), 32'd0);
    step("lock8", 1'b1, 4'd8, 1'b0);
    chk("lock.seg_const", 32'(SEG), 32'h7F);

    // Wrap then mismatch
    step("wrap", 1'b1, 4'd1, 1'b0);
    step("mm4", 1'b1, 4'd4, 1'b0);
    chk("mm.seg_const", 32'(SEG), 32'hC0);
    step("mm_idle", 1'b0, 4'd4, 1'b0);

    // Relock then illegal words
    for (int i = 0; i < 4; i++) step("relock", 1'b1, next_word(), 1'b0);
    step("ill3", 1'b1, 4'b0011, 1'b0);
    step("ill0", 1'b1, 4'b0000, 1'b0);
    step("ill_idle", 1'b0, 4'b0000, 1'b0);

    // Saturation
    for (int i = 0; i < 17; i++) begin
      for (int j = 0; j < 4; j++) step("sat_lock", 1'b1, next_word(), 1'b0);
      step("sat_mm", 1'b1, 4'(m_prev), 1'b0);
    end
    chk("sat.err_const", 32'(err_count), 32'(ERR_MAX));
    chk("sat.dp", 32'(SEG[7]), 32'd1);

    // Strobe gating and repeated samples
    step("gate_rst", 1'b0, 4'd0, 1'b1);
    step("gate_base", 1'b1, 4'd2, 1'b0);
    for (int i = 0; i < 10; i++) step("gate_hold", 1'b0, 4'd2, 1'b0);
    step("rep_a", 1'b1, 4'd2, 1'b0);
    chk("rep.mm_const", 32'(mismatch), 32'd1);
    chk("rep.err_const", 32'(err_count), 32'd0);
    step("rep_b", 1'b1, 4'd2, 1'b0);

    // Reset mid-lock with err_count=5
    step("mid_rst0", 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) step("mid_lock", 1'b1, next_word(), 1'b0);
      step("mid_mm", 1'b1, 4'(m_prev), 1'b0);
    end
    for (int j = 0; j < 4; j++) step("mid_relock", 1'b1, next_word(), 1'b0);
    chk("mid.err5", 32'(err_count), 32'd5);
    chk("mid.locked", 32'(locked), 32'd1);
    step("mid_rst", 1'b1, next_word(), 1'b1);
    chk("mid.seg_const", 32'(SEG), 32'h40);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [3:0] w;
      r = int'($urandom_range(0, 9));
      if (r < 6) w = next_word();
      else if (r < 8) w = 4'(1 << $urandom_range(0, 3));
      else w = 4'($urandom_range(0, 15));
      step("rand", ($urandom_range(0, 3) != 0), w, ($urandom_range(0, 149) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
